// File: rtl/predicate_tracker_if.sv
// rtl/predicate_tracker_if.sv - allocation, delivery, retire and status bundle for predicate_tracker
interface predicate_tracker_if #(
    parameter int DEPTH     = 8,
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = $clog2(DEPTH)
);
    logic                        flush;
    logic                        alloc_valid;
    logic [IDX_W-1:0]            alloc_idx;
    logic                        alloc_pred_en;
    logic                        alloc_pred_true;
    logic [NUM_PORTS-1:0]        deliv_valid;
    logic [NUM_PORTS*IDX_W-1:0]  deliv_idx;
    logic [NUM_PORTS*DATA_W-1:0] deliv_data;
    logic [DEPTH-1:0]            retire;
    logic [DEPTH-1:0]            pred_wait;
    logic [DEPTH-1:0]            pred_pass;
    logic [DEPTH-1:0]            pred_squash;
    logic [CNT_W-1:0]            squash_count;
    logic                        proto_err;

    modport master (
        output flush, alloc_valid, alloc_idx, alloc_pred_en, alloc_pred_true,
               deliv_valid, deliv_idx, deliv_data, retire,
        input  pred_wait, pred_pass, pred_squash, squash_count, proto_err
    );

    modport slave (
        input  flush, alloc_valid, alloc_idx, alloc_pred_en, alloc_pred_true,
               deliv_valid, deliv_idx, deliv_data, retire,
        output pred_wait, pred_pass, pred_squash, squash_count, proto_err
    );
endinterface

// File: rtl/predicate_tracker.sv
// rtl/predicate_tracker.sv - per-slot predicate resolution for the reservation station
module predicate_tracker #(
    parameter int DEPTH     = 8,
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 64,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    predicate_tracker_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} slot_state_t;

    slot_state_t      state_q [DEPTH];
    slot_state_t      state_d [DEPTH];
    logic [DEPTH-1:0] pol_q;
    logic [DEPTH-1:0] pol_d;
    logic [DEPTH-1:0] fail_enter;
    logic             err_set;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_sum;
    logic             proto_err_q;

    // Per-slot next state: retire frees the slot, then allocation, then the winning delivery; flush overrides everything
    always_comb begin : next_state_logic
        logic        hit;
        logic        dbit;
        logic        match;
        logic        alloc_hit;
        slot_state_t base;
        err_set    = 1'b0;
        fail_enter = '0;
        hit        = 1'b0;
        dbit       = 1'b0;
        match      = 1'b0;
        alloc_hit  = 1'b0;
        base       = S_IDLE;
        for (int s = 0; s < DEPTH; s++) begin
            state_d[s] = state_q[s];
            pol_d[s]   = pol_q[s];
            hit        = 1'b0;
            dbit       = 1'b0;
            // Lowest-numbered port targeting this slot wins; any further port is a collision
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.deliv_valid[p] && bus.deliv_idx[p*IDX_W +: IDX_W] == IDX_W'(s)) begin
                    if (hit) begin
                        err_set = 1'b1;
                    end else begin
                        hit  = 1'b1;
                        dbit = bus.deliv_data[p*DATA_W];
                    end
                end
            end
            base = state_q[s];
            if (bus.retire[s]) begin
                if (state_q[s] == S_PASS || state_q[s] == S_FAIL) begin
                    base = S_IDLE;
                end else begin
                    err_set = 1'b1;
                end
            end
            state_d[s] = base;
            alloc_hit  = bus.alloc_valid && (bus.alloc_idx == IDX_W'(s));
            if (alloc_hit && base == S_IDLE) begin
                pol_d[s] = bus.alloc_pred_true;
                if (!bus.alloc_pred_en) begin
                    state_d[s] = S_PASS;
                    if (hit) begin
                        err_set = 1'b1;
                    end
                end else if (hit) begin
                    // Operand arrived together with the allocation: resolve against the new polarity
                    match         = bus.alloc_pred_true ? dbit : ~dbit;
                    state_d[s]    = match ? S_PASS : S_FAIL;
                    fail_enter[s] = ~match;
                end else begin
                    state_d[s] = S_WAIT;
                end
            end else begin
                if (alloc_hit) begin
                    err_set = 1'b1;
                end
                if (hit) begin
                    if (base == S_WAIT) begin
                        match         = pol_q[s] ? dbit : ~dbit;
                        state_d[s]    = match ? S_PASS : S_FAIL;
                        fail_enter[s] = ~match;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
        end
        if (bus.flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                state_d[s] = S_IDLE;
            end
            err_set    = 1'b0;
            fail_enter = '0;
        end
    end

    // Squash counter increment: one per slot entering FAIL, carry bit flags saturation
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int s = 0; s < DEPTH; s++) begin
            cnt_sum = cnt_sum + {{CNT_W{1'b0}}, fail_enter[s]};
        end
    end

    // Slot state, polarity, saturating squash counter and sticky error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                state_q[s] <= S_IDLE;
            end
            pol_q       <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                state_q[s] <= state_d[s];
            end
            pol_q       <= pol_d;
            cnt_q       <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            proto_err_q <= proto_err_q | err_set;
        end
    end

    // Status outputs decode straight from registered state
    always_comb begin
        bus.pred_wait   = '0;
        bus.pred_pass   = '0;
        bus.pred_squash = '0;
        for (int s = 0; s < DEPTH; s++) begin
            bus.pred_wait[s]   = (state_q[s] == S_WAIT);
            bus.pred_pass[s]   = (state_q[s] == S_PASS);
            bus.pred_squash[s] = (state_q[s] == S_FAIL);
        end
        bus.squash_count = cnt_q;
        bus.proto_err    = proto_err_q;
    end
endmodule

// File: tb/tb_predicate_tracker.sv
// tb/tb_predicate_tracker.sv - scoreboard bench for predicate_tracker
module tb_predicate_tracker;
    localparam int DEPTH     = 8;
    localparam int NUM_PORTS = 2;
    localparam int DATA_W    = 64;
    localparam int CNT_W     = 16;
    localparam int IDX_W     = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int M_IDLE    = 0;
    localparam int M_WAIT    = 1;
    localparam int M_PASS    = 2;
    localparam int M_FAIL    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    predicate_tracker_if #(
        .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) bus ();

    predicate_tracker #(
        .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DEPTH-1:0] w;
        logic [DEPTH-1:0] p;
        logic [DEPTH-1:0] q;
        int               cnt;
        bit               err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int m_st  [DEPTH];
    bit m_pol [DEPTH];
    int m_cnt;
    bit m_err;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < DEPTH; s++) begin
            m_st[s]  = M_IDLE;
            m_pol[s] = 1'b0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Reference model: apply the cycle's events in priority order to the slot table
    task automatic model_cycle();
        int nfail = 0;
        bit seen [DEPTH];
        int t;
        bit d;
        for (int s = 0; s < DEPTH; s++) seen[s] = 1'b0;
        if (bus.flush) begin
            for (int s = 0; s < DEPTH; s++) m_st[s] = M_IDLE;
            return;
        end
        for (int s = 0; s < DEPTH; s++) begin
            if (bus.retire[s]) begin
                if (m_st[s] == M_PASS || m_st[s] == M_FAIL) m_st[s] = M_IDLE;
                else m_err = 1'b1;
            end
        end
        if (bus.alloc_valid) begin
            t = int'(bus.alloc_idx);
            if (m_st[t] == M_IDLE) begin
                m_st[t]  = bus.alloc_pred_en ? M_WAIT : M_PASS;
                m_pol[t] = bus.alloc_pred_true;
            end else begin
                m_err = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.deliv_valid[p]) begin
                t = int'(bus.deliv_idx[p*IDX_W +: IDX_W]);
                d = bus.deliv_data[p*DATA_W];
                if (seen[t]) begin
                    m_err = 1'b1;
                end else begin
                    seen[t] = 1'b1;
                    if (m_st[t] == M_WAIT) begin
                        if (d == m_pol[t]) begin
                            m_st[t] = M_PASS;
                        end else begin
                            m_st[t] = M_FAIL;
                            nfail++;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        m_cnt = (m_cnt + nfail > CNT_MAX) ? CNT_MAX : m_cnt + nfail;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.w = '0;
        e.p = '0;
        e.q = '0;
        for (int s = 0; s < DEPTH; s++) begin
            e.w[s] = (m_st[s] == M_WAIT);
            e.p[s] = (m_st[s] == M_PASS);
            e.q[s] = (m_st[s] == M_FAIL);
        end
        e.cnt = m_cnt;
        e.err = m_err;
        return e;
    endfunction

    task automatic clear_inputs();
        bus.flush           = 1'b0;
        bus.alloc_valid     = 1'b0;
        bus.alloc_idx       = '0;
        bus.alloc_pred_en   = 1'b0;
        bus.alloc_pred_true = 1'b0;
        bus.deliv_valid     = '0;
        bus.deliv_idx       = '0;
        bus.deliv_data      = '0;
        bus.retire          = '0;
    endtask

    task automatic set_alloc(int idx, bit en, bit pol);
        bus.alloc_valid     = 1'b1;
        bus.alloc_idx       = IDX_W'(idx);
        bus.alloc_pred_en   = en;
        bus.alloc_pred_true = pol;
    endtask

    task automatic set_deliv(int port, int idx, logic [DATA_W-1:0] data);
        bus.deliv_valid[port]                  = 1'b1;
        bus.deliv_idx[port*IDX_W +: IDX_W]     = IDX_W'(idx);
        bus.deliv_data[port*DATA_W +: DATA_W]  = data;
    endtask

    // Issue the current inputs for one clock and queue the expected outputs
    task automatic cycle();
        model_cycle();
        sb.push_back(model_outputs());
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_wait"}, bus.pred_wait, 0);
        check({tag, "_pass"}, bus.pred_pass, 0);
        check({tag, "_squash"}, bus.pred_squash, 0);
        check({tag, "_count"}, bus.squash_count, 0);
        check({tag, "_err"}, bus.proto_err, 0);
    endtask

    // Reset asserted between clock edges must clear outputs immediately
    task automatic async_reset(string tag);
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic int pick_target();
        int waits[$];
        for (int s = 0; s < DEPTH; s++) if (m_st[s] == M_WAIT) waits.push_back(s);
        if (waits.size() > 0 && $urandom_range(0, 3) != 0)
            return waits[$urandom_range(0, waits.size() - 1)];
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    // Monitor: outputs are valid every cycle, compare against the queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("mon_wait", bus.pred_wait, mon_e.w);
                check("mon_pass", bus.pred_pass, mon_e.p);
                check("mon_squash", bus.pred_squash, mon_e.q);
                check("mon_count", bus.squash_count, mon_e.cnt);
                check("mon_err", bus.proto_err, mon_e.err);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Predicated alloc, later delivery, retire
        clear_inputs(); set_alloc(3, 1, 1); cycle();
        check("t1_wait3", bus.pred_wait[3], 1);
        clear_inputs(); set_deliv(0, 3, 64'h1); cycle();
        check("t1_pass3", bus.pred_pass[3], 1);
        check("t1_nowait3", bus.pred_wait[3], 0);
        clear_inputs(); bus.retire[3] = 1'b1; cycle();
        check("t1_idle3", {bus.pred_wait[3], bus.pred_pass[3], bus.pred_squash[3]}, 0);
        check("t1_err", bus.proto_err, 0);

        // Same-cycle alloc and delivery, then unpredicated alloc
        clear_inputs(); set_alloc(5, 1, 0); set_deliv(0, 5, 64'h1); cycle();
        check("t2_squash5", bus.pred_squash[5], 1);
        check("t2_count", bus.squash_count, 1);
        clear_inputs(); set_alloc(2, 0, 0); cycle();
        check("t2_pass2", bus.pred_pass[2], 1);

        // Retire of an IDLE slot, delivery to a PASS slot
        clear_inputs(); bus.retire[7] = 1'b1; cycle();
        check("t6_err", bus.proto_err, 1);
        check("t6_pass", bus.pred_pass, 8'h04);
        check("t6_squash", bus.pred_squash, 8'h20);
        clear_inputs(); set_deliv(0, 2, 64'h0); cycle();
        check("t6_pass_kept", bus.pred_pass, 8'h04);
        check("t6_squash_kept", bus.pred_squash, 8'h20);
        check("t6_err_sticky", bus.proto_err, 1);

        async_reset("rst1");

        // Both ports hit WAIT slot 4: port 0 wins
        clear_inputs(); set_alloc(4, 1, 1); cycle();
        clear_inputs(); set_deliv(0, 4, 64'h1); set_deliv(1, 4, 64'h0); cycle();
        check("t3_pass4", bus.pred_pass[4], 1);
        check("t3_err", bus.proto_err, 1);
        check("t3_count", bus.squash_count, 0);

        // Fill all slots, squash two per cycle
        clear_inputs(); bus.retire[4] = 1'b1; cycle();
        for (int i = 0; i < DEPTH; i++) begin
            clear_inputs(); set_alloc(i, 1, 1); cycle();
        end
        check("t4_allwait", bus.pred_wait, 8'hFF);
        for (int i = 0; i < DEPTH; i += 2) begin
            clear_inputs(); set_deliv(0, i, 64'h0); set_deliv(1, i + 1, 64'h2); cycle();
        end
        check("t4_count8", bus.squash_count, 8);
        check("t4_allsquash", bus.pred_squash, 8'hFF);

        // Flush with mixed slot states and a same-cycle alloc
        clear_inputs(); bus.retire = 8'hFF; cycle();
        clear_inputs(); set_alloc(1, 0, 0); cycle();
        clear_inputs(); set_alloc(2, 1, 1); cycle();
        clear_inputs(); set_alloc(3, 1, 1); set_deliv(1, 3, 64'h0); cycle();
        clear_inputs(); set_alloc(4, 1, 0); cycle();
        clear_inputs(); set_alloc(5, 0, 1); cycle();
        clear_inputs(); set_alloc(6, 1, 0); set_deliv(0, 6, 64'hFFFF_FFFF_FFFF_FFFE); cycle();
        check("fl_pre_count", bus.squash_count, 9);
        check("fl_pre_pass", bus.pred_pass, 8'h62);
        clear_inputs(); bus.flush = 1'b1; set_alloc(0, 1, 1); set_deliv(0, 2, 64'h1);
        bus.retire[1] = 1'b1; cycle();
        check("fl_wait", bus.pred_wait, 0);
        check("fl_pass", bus.pred_pass, 0);
        check("fl_squash", bus.pred_squash, 0);
        check("fl_count", bus.squash_count, 9);
        check("fl_err", bus.proto_err, 1);

        // Reset while a slot is waiting
        clear_inputs(); set_alloc(2, 1, 1); cycle();
        check("rst2_pre_wait", bus.pred_wait[2], 1);
        async_reset("rst2");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            bus.flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                set_alloc(int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)));
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_deliv(p, pick_target(), {$urandom, $urandom});
            end
            for (int s = 0; s < DEPTH; s++) begin
                if ((m_st[s] == M_PASS || m_st[s] == M_FAIL) && $urandom_range(0, 2) == 0)
                    bus.retire[s] = 1'b1;
                else if ($urandom_range(0, 31) == 0)
                    bus.retire[s] = 1'b1;
            end
            cycle();
        end

        // Drive the squash counter into saturation, one squash per cycle on slot 0
        for (int i = 0; i < 70000 && m_cnt < CNT_MAX; i++) begin
            clear_inputs();
            if (m_st[0] == M_PASS || m_st[0] == M_FAIL) bus.retire[0] = 1'b1;
            set_alloc(0, 1, 1);
            set_deliv(0, 0, 64'h0);
            cycle();
        end
        check("sat_reached", bus.squash_count, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            if (m_st[0] == M_PASS || m_st[0] == M_FAIL) bus.retire[0] = 1'b1;
            set_alloc(0, 1, 1);
            set_deliv(0, 0, 64'h0);
            cycle();
        end
        check("sat_held", bus.squash_count, 16'hFFFF);

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
